// File: rtl/bcd2bin_seq.sv
// Purpose: sequential BCD-to-binary converter, MSD first, Horner acc = acc*10 + digit.
// Latency: NDIG cycles from accepted start to done (1 cycle for an invalid-digit reject).
// Backpressure: none; start is sampled only in IDLE, and a start while busy is dropped.
module bcd2bin_seq #(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] BCD,
    output logic [BW-1:0]     B,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t            r_state, w_state;
    logic [4*NDIG-1:0] r_shadow, w_shadow;
    logic [BW-1:0]     r_acc, w_acc;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [BW-1:0]     r_b, w_b;
    logic              r_done, w_done;
    logic              r_err, w_err;

    logic              w_bad;
    logic [3:0]        w_digit;
    logic [BW-1:0]     w_acc_step;

    // Flag any input digit above 9; such a request is rejected without converting.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (BCD[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // One Horner step on the latched digit selected by the countdown counter.
    assign w_digit    = r_shadow[{r_cnt, 2'b00} +: 4];
    assign w_acc_step = (r_acc << 3) + (r_acc << 1) + {{(BW-4){1'b0}}, w_digit};

    // Next-state and datapath updates; outputs hold unless explicitly changed.
    always_comb begin
        w_state  = r_state;
        w_shadow = r_shadow;
        w_acc    = r_acc;
        w_cnt    = r_cnt;
        w_b      = r_b;
        w_err    = r_err;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_b    = '0;
                        w_err  = 1'b1;
                        w_done = 1'b1;
                    end else begin
                        w_shadow = BCD;
                        w_acc    = '0;
                        w_cnt    = CW'(NDIG - 1);
                        w_err    = 1'b0;
                        w_state  = S_CONV;
                    end
                end
            end
            S_CONV: begin
                w_acc = w_acc_step;
                if (r_cnt == '0) begin
                    w_b     = w_acc_step;
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shadow <= w_shadow;
            r_acc    <= w_acc;
            r_cnt    <= w_cnt;
            r_b      <= w_b;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    assign B    = r_b;
    assign busy = (r_state == S_CONV);
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Purpose: self-checking bench for bcd2bin_seq (table vectors, corner sequences, loopback).
// Latency: expects done NDIG edges after an accepted start, one edge after a reject.
// Backpressure: checks that a start during busy is dropped and a start in the done cycle is taken.
module tb_bcd2bin_seq;

    localparam int NDIG = 4;
    localparam int BW   = 14;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] BCD;
    logic [BW-1:0]     B;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4*NDIG-1:0] bcd;
        logic [BW-1:0]     b;
        logic              e;
    } vec_t;

    typedef struct {
        logic [BW-1:0] b;
        logic          e;
    } exp_t;

    exp_t sb[$];

    bcd2bin_seq #(.NDIG(NDIG), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .BCD   (BCD),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge where 'seen' negedges have passed since the start edge.
    task automatic wait_done(input int seen, input int exp_busy);
        int   cyc;
        int   nbusy;
        bit   got;
        exp_t x;
        cyc   = seen;
        nbusy = 0;
        got   = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("B", 32'(B), 32'(x.b));
                    chk("err", 32'(err), 32'(x.e));
                    chk("done_cycle", cyc, x.e ? 1 : NDIG + 1);
                    chk("busy_cycles", nbusy, exp_busy);
                    chk("busy_at_done", 32'(busy), 0);
                end
            end else begin
                if (busy === 1'b1) nbusy++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input logic [4*NDIG-1:0] bcd, input logic [BW-1:0] b, input logic e);
        @(negedge clk);
        BCD   = bcd;
        start = 1'b1;
        sb.push_back('{b: b, e: e});
        @(negedge clk);
        start = 1'b0;
        BCD   = ~bcd;
        wait_done(1, e ? 0 : NDIG);
        @(negedge clk);
        chk("done_pulse_len", 32'(done), 0);
        chk("B_hold", 32'(B), 32'(b));
        chk("err_hold", 32'(err), 32'(e));
    endtask

    function automatic logic [4*NDIG-1:0] to_bcd(input int v);
        logic [4*NDIG-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    vec_t vecs[8];
    int   loop_vals[8];
    int   extra_done;

    initial begin
        vecs[0] = '{bcd: 16'h0777, b: 14'd777,  e: 1'b0};
        vecs[1] = '{bcd: 16'h9999, b: 14'd9999, e: 1'b0};
        vecs[2] = '{bcd: 16'h0000, b: 14'd0,    e: 1'b0};
        vecs[3] = '{bcd: 16'h1000, b: 14'd1000, e: 1'b0};
        vecs[4] = '{bcd: 16'h12A4, b: 14'd0,    e: 1'b1};
        vecs[5] = '{bcd: 16'h0042, b: 14'd42,   e: 1'b0};
        vecs[6] = '{bcd: 16'hF000, b: 14'd0,    e: 1'b1};
        vecs[7] = '{bcd: 16'h8051, b: 14'd8051, e: 1'b0};
        loop_vals = '{0, 1, 9, 10, 99, 777, 1234, 9999};

        rst_n = 1'b0;
        start = 1'b0;
        BCD   = '0;
        #1;
        chk("rst_B", 32'(B), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Table of vectors; an invalid entry followed by a valid one checks err clears.
        for (int i = 0; i < 8; i++) begin
            run(vecs[i].bcd, vecs[i].b, vecs[i].e);
        end

        // Start pulsed during busy with new digits: must be ignored entirely.
        @(negedge clk);
        BCD   = 16'h0777;
        start = 1'b1;
        sb.push_back('{b: 14'd777, e: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        BCD   = 16'h0123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, NDIG - 2);
        extra_done = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        chk("no_second_done", extra_done, 0);
        chk("B_after_ignore", 32'(B), 777);

        // Back-to-back: start asserted in the done cycle is accepted.
        @(negedge clk);
        BCD   = 16'h0321;
        start = 1'b1;
        sb.push_back('{b: 14'd321, e: 1'b0});
        @(negedge clk);
        start = 1'b0;
        wait_done(1, NDIG);
        BCD   = 16'h4567;
        start = 1'b1;
        sb.push_back('{b: 14'd4567, e: 1'b0});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_fell", 32'(done), 0);
        chk("b2b_busy", 32'(busy), 1);
        wait_done(1, NDIG);

        // Asynchronous reset mid-conversion, then a normal conversion.
        @(negedge clk);
        BCD   = 16'h0777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        chk("arst_B", 32'(B), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        #2;
        rst_n = 1'b1;
        run(16'h0042, 14'd42, 1'b0);

        // Loopback against an independent binary-to-BCD model.
        foreach (loop_vals[i]) begin
            run(to_bcd(loop_vals[i]), BW'(loop_vals[i]), 1'b0);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
